// File: rtl/dmem_arb_pkg.sv
// Shared encodings and constants for the data-memory arbiter.
// Imported by the picker and the top-level sequencer.
package dmem_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_e;

  localparam logic [9:0]  GPO_ADDR_DEFAULT = 10'h050;
  localparam logic [23:0] GPO_RD_ZEXT      = 24'h00_0000;

  // GPO is an 8-bit register; the upper bits read back as zero.
  function automatic logic [31:0] gpo_rdata(input logic [7:0] gpo_val);
    return {GPO_RD_ZEXT, gpo_val};
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// One requester port of the data-memory arbiter (CPU or external loader).
// master = requester side, slave = arbiter side.
interface dmem_arb_if #(
  parameter int ADDR_W = 10
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Grant selector: one-hot grant from the request pair.
// Define DMEM_ARB_RR_EN for round-robin contention; default is CPU priority with a starvation limit.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic ext_req,
  output logic cpu_gnt,
  output logic ext_gnt
);

  logic contested;
  logic ext_wins;

  assign contested = cpu_req & ext_req;

`ifdef DMEM_ARB_RR_EN

  req_e last_winner_q;
  req_e last_winner_d;

  always_comb begin
    ext_wins      = ext_req;
    last_winner_d = last_winner_q;
    if (contested) begin
      ext_wins      = (last_winner_q == REQ_CPU);
      last_winner_d = (last_winner_q == REQ_CPU) ? REQ_EXT : REQ_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= REQ_CPU;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

`else

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  // The counter only survives unbroken contention that CPU keeps winning.
  always_comb begin
    ext_wins     = contested ? (starve_cnt_q == LIMIT) : ext_req;
    starve_cnt_d = 4'd0;
    if (contested && !ext_wins) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`endif

  assign ext_gnt = rst_n & ext_wins;
  assign cpu_gnt = rst_n & cpu_req & ~ext_wins;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory and the GPO register.
// Optional build macro DMEM_ARB_RR_EN selects round-robin contention (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] GPO_ADDR     = ADDR_W'(GPO_ADDR_DEFAULT),
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arb_if.slave         cpu,
  dmem_arb_if.slave         ext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_width,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  output logic              gpo_write,
  output logic [7:0]        gpo_data,
  input  logic [7:0]        gpo_in
);

  logic cpu_gnt;
  logic ext_gnt;
  logic any_gnt;
  logic acc_we;
  logic hit_gpo;

  logic rd_pending_q, rd_pending_d;
  req_e rd_owner_q,   rd_owner_d;
  logic rd_is_gpo_q,  rd_is_gpo_d;

  logic [31:0] rd_data;
  logic        cpu_rvalid;
  logic        ext_rvalid;

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu.req),
    .ext_req (ext.req),
    .cpu_gnt (cpu_gnt),
    .ext_gnt (ext_gnt)
  );

  assign cpu.gnt = cpu_gnt;
  assign ext.gnt = ext_gnt;
  assign any_gnt = cpu_gnt | ext_gnt;

  // With no grant the CPU fields sit on the bus; strobes stay low.
  always_comb begin
    mem_addr  = cpu.addr;
    mem_wdata = cpu.wdata;
    mem_width = cpu.be;
    acc_we    = cpu.we;
    if (ext_gnt) begin
      mem_addr  = ext.addr;
      mem_wdata = ext.wdata;
      mem_width = ext.be;
      acc_we    = ext.we;
    end
    hit_gpo   = (mem_addr == GPO_ADDR);
    gpo_data  = mem_wdata[7:0];
    mem_write = any_gnt & acc_we & ~hit_gpo;
    gpo_write = any_gnt & acc_we & hit_gpo;
  end

  always_comb begin
    rd_pending_d = any_gnt & ~acc_we;
    rd_owner_d   = ext_gnt ? REQ_EXT : REQ_CPU;
    rd_is_gpo_d  = hit_gpo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= REQ_CPU;
      rd_is_gpo_q  <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      rd_is_gpo_q  <= rd_is_gpo_d;
    end
  end

  // Memory output is already registered, so the return is a pure mux on the pending tag.
  always_comb begin
    rd_data    = rd_is_gpo_q ? gpo_rdata(gpo_in) : mem_rdata;
    cpu_rvalid = rd_pending_q & (rd_owner_q == REQ_CPU);
    ext_rvalid = rd_pending_q & (rd_owner_q == REQ_EXT);
  end

  assign cpu.rvalid = cpu_rvalid;
  assign ext.rvalid = ext_rvalid;
  assign cpu.rdata  = cpu_rvalid ? rd_data : 32'h0;
  assign ext.rdata  = ext_rvalid ? rd_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single-cycle vectors plus
// hand-written contention, starvation and reset-mid-read sequences.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        gpo_write;
  logic [7:0]  gpo_data;
  logic [7:0]  gpo_in;

  int total_cnt;
  int pass_cnt;

  dmem_arb_if #(.ADDR_W(10)) cpu_bus ();
  dmem_arb_if #(.ADDR_W(10)) ext_bus ();

  dmem_arbiter #(
    .ADDR_W       (10),
    .GPO_ADDR     (10'h050),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu_bus),
    .ext       (ext_bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_width (mem_width),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .gpo_write (gpo_write),
    .gpo_data  (gpo_data),
    .gpo_in    (gpo_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [9:0]  c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        e_req;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] m_rdata;
    logic [7:0]  g_in;
    logic        x_cgnt;
    logic        x_egnt;
    logic        x_mwrite;
    logic [9:0]  x_maddr;
    logic [3:0]  x_mwidth;
    logic        x_gwrite;
    logic [7:0]  x_gdata;
    logic        x_crvalid;
    logic        x_ervalid;
    logic [31:0] x_crdata;
    logic [31:0] x_erdata;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_bus.req   = v.c_req;
    cpu_bus.we    = v.c_we;
    cpu_bus.addr  = v.c_addr;
    cpu_bus.wdata = v.c_wdata;
    cpu_bus.be    = v.c_be;
    ext_bus.req   = v.e_req;
    ext_bus.we    = v.e_we;
    ext_bus.addr  = v.e_addr;
    ext_bus.wdata = v.e_wdata;
    ext_bus.be    = v.e_be;
    mem_rdata     = v.m_rdata;
    gpo_in        = v.g_in;
  endtask

  task automatic driveReads(input logic c_req, input logic e_req);
    cpu_bus.req   = c_req;
    cpu_bus.we    = 1'b0;
    cpu_bus.addr  = 10'h040;
    cpu_bus.wdata = 32'h0;
    cpu_bus.be    = 4'hF;
    ext_bus.req   = e_req;
    ext_bus.we    = 1'b0;
    ext_bus.addr  = 10'h044;
    ext_bus.wdata = 32'h0;
    ext_bus.be    = 4'hF;
  endtask

  task automatic checkGrants(input string tag, input int i, input logic x_cgnt, input logic x_egnt);
    checkOutput($sformatf("%s[%0d].cpu_gnt", tag, i), {31'b0, cpu_bus.gnt}, {31'b0, x_cgnt});
    checkOutput($sformatf("%s[%0d].ext_gnt", tag, i), {31'b0, ext_bus.gnt}, {31'b0, x_egnt});
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;

    //        cpu: req we addr    wdata          be    ext: req we addr    wdata          be    mem_rdata      gpo_in   exp: cg eg mw maddr   mwid  gw gdata  crv erv crdata         erdata
    vecs[0]  = '{1'b1, 1'b1, 10'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h0,        8'h00, 1'b1, 1'b0, 1'b1, 10'h100, 4'hF, 1'b0, 8'hEF, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 10'h100, 32'h0,        4'hF, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h0,        8'h00, 1'b1, 1'b0, 1'b0, 10'h100, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'hDEADBEEF, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 10'h050, 32'h000000A5, 4'h1, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h0,        8'h00, 1'b1, 1'b0, 1'b0, 10'h050, 4'h1, 1'b1, 8'hA5, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 10'h050, 32'h0,        4'hF, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h0,        8'h00, 1'b1, 1'b0, 1'b0, 10'h050, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h12345678, 8'hA5, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h000000A5, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 10'h010, 32'h0,        4'hF, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h0,        8'h00, 1'b1, 1'b0, 1'b0, 10'h010, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 1'b0, 10'h020, 32'h0,        4'hF, 32'h11112222, 8'h00, 1'b0, 1'b1, 1'b0, 10'h020, 4'hF, 1'b0, 8'h00, 1'b1, 1'b0, 32'h11112222, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h33334444, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        32'h33334444};
    vecs[9]  = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 1'b1, 10'h200, 32'hCAFEF00D, 4'h3, 32'h0,        8'h00, 1'b0, 1'b1, 1'b1, 10'h200, 4'h3, 1'b0, 8'h0D, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 1'b1, 10'h050, 32'h0000005A, 4'hF, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 10'h050, 4'hF, 1'b1, 8'h5A, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b1, 10'h104, 32'h00000001, 4'hF, 1'b1, 1'b0, 10'h030, 32'h0,        4'hF, 32'h0,        8'h00, 1'b1, 1'b0, 1'b1, 10'h104, 4'hF, 1'b0, 8'h01, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b1, 1'b0, 10'h050, 32'h0,        4'hF, 32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 10'h050, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b0, 1'b0, 10'h000, 32'h0,        4'h0, 32'hFFFFFFFF, 8'h3C, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,        32'h0000003C};

    // Reset state with a pending CPU write request on the bus.
    rst_n = 1'b0;
    applyStimulus(vecs[0]);
    #2;
    checkOutput("reset.cpu_gnt",    {31'b0, cpu_bus.gnt},    32'h0);
    checkOutput("reset.ext_gnt",    {31'b0, ext_bus.gnt},    32'h0);
    checkOutput("reset.mem_write",  {31'b0, mem_write},      32'h0);
    checkOutput("reset.gpo_write",  {31'b0, gpo_write},      32'h0);
    checkOutput("reset.cpu_rvalid", {31'b0, cpu_bus.rvalid}, 32'h0);
    checkOutput("reset.ext_rvalid", {31'b0, ext_bus.rvalid}, 32'h0);
    checkOutput("reset.cpu_rdata",  cpu_bus.rdata,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.cpu_gnt", i),    {31'b0, cpu_bus.gnt},    {31'b0, vecs[i].x_cgnt});
      checkOutput($sformatf("v%0d.ext_gnt", i),    {31'b0, ext_bus.gnt},    {31'b0, vecs[i].x_egnt});
      checkOutput($sformatf("v%0d.mem_write", i),  {31'b0, mem_write},      {31'b0, vecs[i].x_mwrite});
      checkOutput($sformatf("v%0d.mem_addr", i),   {22'b0, mem_addr},       {22'b0, vecs[i].x_maddr});
      checkOutput($sformatf("v%0d.mem_width", i),  {28'b0, mem_width},      {28'b0, vecs[i].x_mwidth});
      checkOutput($sformatf("v%0d.gpo_write", i),  {31'b0, gpo_write},      {31'b0, vecs[i].x_gwrite});
      checkOutput($sformatf("v%0d.gpo_data", i),   {24'b0, gpo_data},       {24'b0, vecs[i].x_gdata});
      checkOutput($sformatf("v%0d.cpu_rvalid", i), {31'b0, cpu_bus.rvalid}, {31'b0, vecs[i].x_crvalid});
      checkOutput($sformatf("v%0d.ext_rvalid", i), {31'b0, ext_bus.rvalid}, {31'b0, vecs[i].x_ervalid});
      checkOutput($sformatf("v%0d.cpu_rdata", i),  cpu_bus.rdata,           vecs[i].x_crdata);
      checkOutput($sformatf("v%0d.ext_rdata", i),  ext_bus.rdata,           vecs[i].x_erdata);
      if (vecs[i].x_cgnt && vecs[i].x_mwrite) begin
        checkOutput($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].c_wdata);
      end
    end

    // Continuous contention: CPU,CPU,CPU,CPU,EXT repeating; rvalid follows the previous winner.
    mem_rdata = 32'h0;
    gpo_in    = 8'h00;
    begin
      logic prev_cpu;
      logic prev_ext;
      logic x_ext;
      prev_cpu = 1'b0;
      prev_ext = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        driveReads(1'b1, 1'b1);
        #1;
        x_ext = ((i % 5) == 4);
        checkGrants("starve", i, ~x_ext, x_ext);
        checkOutput($sformatf("starve[%0d].cpu_rvalid", i), {31'b0, cpu_bus.rvalid}, {31'b0, prev_cpu});
        checkOutput($sformatf("starve[%0d].ext_rvalid", i), {31'b0, ext_bus.rvalid}, {31'b0, prev_ext});
        prev_cpu = ~x_ext;
        prev_ext = x_ext;
      end
    end

    // Ext alone for 10 cycles; this also clears the leftover starvation count.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      driveReads(1'b0, 1'b1);
      #1;
      checkGrants("ext_only", i, 1'b0, 1'b1);
    end

    // Counter must restart from zero: four CPU wins before ext is forced in.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      driveReads(1'b1, 1'b1);
      #1;
      checkGrants("after_ext", i, (i != 4), (i == 4));
    end

    // Two contested CPU reads, then reset while the second read is returning.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      driveReads(1'b1, 1'b1);
      #1;
      checkGrants("pre_rst", i, 1'b1, 1'b0);
    end
    @(posedge clk);
    #1;
    checkOutput("pre_rst.cpu_rvalid", {31'b0, cpu_bus.rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst.cpu_rvalid", {31'b0, cpu_bus.rvalid}, 32'h0);
    checkOutput("mid_rst.cpu_rdata",  cpu_bus.rdata,           32'h0);
    checkOutput("mid_rst.cpu_gnt",    {31'b0, cpu_bus.gnt},    32'h0);
    checkOutput("mid_rst.ext_gnt",    {31'b0, ext_bus.gnt},    32'h0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      driveReads(1'b1, 1'b1);
      #1;
      checkGrants("post_rst", i, (i != 4), (i == 4));
    end

    @(negedge clk);
    driveReads(1'b0, 1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and bus sequencer in front of the single-port data memory and the GPO peripheral. Shares the memory between the CPU load/store port and an external requester (loader/debug port). Grants one access per cycle, decodes the GPO address, and routes the 1-cycle-latency read data back to the correct requester. Sits between the pipeline MEM stage and the data memory / GPO instances in the top level.

Parameters:
ADDR_W, 10, byte address width of both requester ports and the memory port
GPO_ADDR, 10'h050, address decoded as the GPO register; never forwarded as a memory write
STARVE_LIMIT, 4, maximum consecutive contested cycles CPU may win before ext is forced a grant (1..15)

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
cpu_req / ext_req  input  1  access request; held with fields stable until gnt
cpu_we / ext_we  input  1  1 = write, 0 = read
cpu_addr / ext_addr  input  ADDR_W  byte address
cpu_wdata / ext_wdata  input  32  write data
cpu_be / ext_be  input  4  byte enables, passed unchanged to the memory width field
cpu_gnt / ext_gnt  output  1  combinational; access accepted this cycle
cpu_rvalid / ext_rvalid  output  1  registered; read data valid this cycle
cpu_rdata / ext_rdata  output  32  read data, qualified by rvalid
mem_addr  output  ADDR_W  to data memory address
mem_wdata  output  32  to data memory data_in
mem_width  output  4  to data memory width
mem_write  output  1  to data memory write
mem_rdata  input  32  from data memory data_out (registered inside memory)
gpo_write  output  1  GPO register write strobe
gpo_data  output  8  granted wdata[7:0]
gpo_in  input  8  current GPO value, for read-back

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. While rst_n=0: both gnt=0, mem_write=0, gpo_write=0; registered state cleared: rvalid=0, rdata=0, starve_cnt=0, last_winner=CPU, rd_pending=0.
- Grant (combinational): only one gnt high per cycle. Single requester: it is granted. Both: CPU wins unless starve_cnt==STARVE_LIMIT, then ext wins.
- starve_cnt: +1 when both request and CPU wins; clears to 0 when ext granted or ext_req=0; saturates at STARVE_LIMIT.
- Datapath mux: winner's addr/wdata/be drive mem_*; with no grant, CPU fields are driven and mem_write=0.
- Write, accepted cycle T: addr!=GPO_ADDR -> mem_write=1, mem_width=be. addr==GPO_ADDR -> gpo_write=1, mem_write=0. Completes at the edge ending T. No rvalid.
- Read, accepted cycle T: register rd_pending=1, rd_owner, rd_is_gpo. In T+1, owner rvalid=1 with rdata=mem_rdata, or {24'b0,gpo_in} when rd_is_gpo. Other requester rvalid=0. Read latency is exactly 1 cycle after gnt.
- Pipelining: a new grant may issue in T+1 while the previous read returns. Back-to-back reads give rvalid every cycle. No stall or backpressure on return data.
- Read-after-write to the same address on consecutive grants returns the new data.
- Data byte-ordering is owned by the memory. The arbiter passes rdata/wdata unmodified.
- Reset mid-read: rvalid drops in the same cycle rst_n falls and the pending read is discarded.

Optional Feature:
DMEM_ARB_RR_EN. Defined: contention resolved round-robin. Winner is the requester not recorded in last_winner, which updates on every contested grant. starve_cnt and STARVE_LIMIT are unused and not instantiated. Undefined: fixed CPU priority with the starvation counter as above.

Decomposition:
- Package dmem_arb_pkg: REQ_CPU=1'b0 and REQ_EXT=1'b1 encodings, default GPO_ADDR, and the 32-bit GPO read-back zero-extension constant.
- One sub-module, dmem_arb_pick: req pair, starve/last_winner state -> one-hot grant. Contains all DMEM_ARB_RR_EN conditionals.

Test Plan:
- CPU write addr 0x100, wdata 0xDEADBEEF, be 4'hF, ext idle -> cpu_gnt=1 same cycle, mem_write=1, mem_addr=0x100, mem_width=4'hF; then CPU read 0x100 -> cpu_rvalid=1 next cycle, cpu_rdata=mem_rdata, ext_rvalid=0.
- Both requesting continuously, STARVE_LIMIT=4 -> grant pattern CPU,CPU,CPU,CPU,EXT repeating; with DMEM_ARB_RR_EN -> CPU,EXT,CPU,EXT.
- CPU write addr 0x050, wdata 0x000000A5 -> gpo_write=1, gpo_data=0xA5, mem_write=0. CPU read 0x050 with gpo_in=0xA5 -> cpu_rdata=0x000000A5 one cycle later.
- Back-to-back reads: CPU 0x10 at T, ext 0x20 at T+1 (CPU idle) -> cpu_rvalid at T+1, ext_rvalid at T+2, never both high.
- rst_n low during the cycle after a granted read -> cpu_rvalid=0 immediately, gnts=0. After release, the first request is granted with starve_cnt=0.
- ext_req alone for 10 cycles -> ext_gnt=1 every cycle, starve_cnt stays 0.
